// File: rtl/msg_queue_pkg.sv
// Shared definitions for the multi-channel message queue: CPU register map,
// memory window base, ctrl/status bit positions and ring pointer helpers.
package msg_queue_pkg;

    // Start of the ring memory window in the CPU word-address space
    localparam int unsigned MEM_BASE = 'h400;

    // Per-channel register offsets (addr[2:0] inside the register window)
    typedef enum logic [2:0] {
        REG_IN_RD_PTR  = 3'd0,
        REG_IN_WR_PTR  = 3'd1,
        REG_OUT_RD_PTR = 3'd2,
        REG_OUT_WR_PTR = 3'd3,
        REG_CTRL       = 3'd4,
        REG_STATUS     = 3'd5,
        REG_WATERMARK  = 3'd6,
        REG_RESERVED   = 3'd7
    } reg_off_e;

    // ctrl register bits
    localparam int CTRL_IN_IE  = 0;
    localparam int CTRL_OUT_IE = 1;

    // status register bits
    localparam int STAT_IN_AVAIL  = 0;
    localparam int STAT_OUT_SPACE = 1;
    localparam int STAT_PTR_ERR   = 2;

    // Distance from b forward to a, modulo 2**w (pointers carry a wrap bit)
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        return (a - b) & ((32'd1 << w) - 32'd1);
    endfunction

    // A ring is full when it holds exactly DEPTH entries
    function automatic logic ring_full(input logic [31:0] cnt,
                                       input int unsigned depth);
        return cnt == depth;
    endfunction

    // A ring is empty when the pointers coincide
    function automatic logic ring_empty(input logic [31:0] cnt);
        return cnt == 32'd0;
    endfunction

endpackage

// File: rtl/msg_queue_chan.sv
// One message queue channel: inbound ring (stream -> CPU), outbound ring
// (CPU -> stream), their pointers, ctrl/status registers and the IRQ
// condition. Optional feature macro: MSG_QUEUE_WATERMARK_EN adds a per-channel
// watermark register that qualifies the inbound status bit.
module msg_queue_chan
    import msg_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               reg_sel,
    input  logic                     reg_we,
    input  logic [31:0]              wdata,
    input  logic                     mem_dir,
    input  logic [$clog2(DEPTH)-1:0] mem_idx,
    input  logic                     mem_we,
    output logic [31:0]              reg_rdata,
    output logic [31:0]              mem_rdata,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic                     irq_cond
);

    localparam int LOG_D = $clog2(DEPTH);
    localparam int PTR_W = LOG_D + 1;

    logic [PTR_W-1:0]  in_rd_q, in_rd_d;
    logic [PTR_W-1:0]  in_wr_q, in_wr_d;
    logic [PTR_W-1:0]  out_rd_q, out_rd_d;
    logic [PTR_W-1:0]  out_wr_q, out_wr_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              ptr_err_q, ptr_err_d;
`ifdef MSG_QUEUE_WATERMARK_EN
    logic [PTR_W-1:0]  wmark_q, wmark_d;
    logic [PTR_W-1:0]  wmark_eff;
`endif

    logic [DATA_W-1:0] in_ring_q  [DEPTH];
    logic [DATA_W-1:0] out_ring_q [DEPTH];

    logic [PTR_W-1:0]  in_count, out_count;
    logic [PTR_W-1:0]  new_ptr, in_rd_span, out_wr_span;
    logic              push, pop;
    logic [2:0]        status;
    logic              unused_wdata;

    assign unused_wdata = ^wdata;

    // Occupancy of each ring and the handshake qualifiers derived from it
    always_comb begin
        in_count  = PTR_W'(ptr_diff(32'(in_wr_q), 32'(in_rd_q), PTR_W));
        out_count = PTR_W'(ptr_diff(32'(out_wr_q), 32'(out_rd_q), PTR_W));
        in_ready  = !ring_full(32'(in_count), DEPTH);
        out_valid = !ring_empty(32'(out_count));
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = out_ring_q[out_rd_q[LOG_D-1:0]];
    end

    // Status bits and the interrupt condition this channel contributes
    always_comb begin
`ifdef MSG_QUEUE_WATERMARK_EN
        wmark_eff = (wmark_q == '0) ? PTR_W'(1) : wmark_q;
        status[STAT_IN_AVAIL] = (in_count >= wmark_eff);
`else
        status[STAT_IN_AVAIL] = !ring_empty(32'(in_count));
`endif
        status[STAT_OUT_SPACE] = !ring_full(32'(out_count), DEPTH);
        status[STAT_PTR_ERR]   = ptr_err_q;
        irq_cond = (ctrl_q[CTRL_IN_IE] && status[STAT_IN_AVAIL]) ||
                   (ctrl_q[CTRL_OUT_IE] && status[STAT_OUT_SPACE]);
    end

    // Next-state of pointers and registers: stream handshakes advance the
    // hardware-owned pointers, CPU writes update the software-owned ones
    // after a range check against the current ring contents
    always_comb begin
        in_rd_d     = in_rd_q;
        in_wr_d     = in_wr_q;
        out_rd_d    = out_rd_q;
        out_wr_d    = out_wr_q;
        ctrl_d      = ctrl_q;
        ptr_err_d   = ptr_err_q;
`ifdef MSG_QUEUE_WATERMARK_EN
        wmark_d     = wmark_q;
`endif
        new_ptr     = wdata[PTR_W-1:0];
        in_rd_span  = PTR_W'(ptr_diff(32'(in_wr_q), 32'(new_ptr), PTR_W));
        out_wr_span = PTR_W'(ptr_diff(32'(new_ptr), 32'(out_rd_q), PTR_W));

        if (push) begin
            in_wr_d = in_wr_q + PTR_W'(1);
        end
        if (pop) begin
            out_rd_d = out_rd_q + PTR_W'(1);
        end

        if (reg_we) begin
            case (reg_off_e'(reg_sel))
                REG_IN_RD_PTR: begin
                    if (in_rd_span <= in_count) begin
                        in_rd_d = new_ptr;
                    end else begin
                        ptr_err_d = 1'b1;
                    end
                end
                REG_OUT_WR_PTR: begin
                    if (out_wr_span <= PTR_W'(DEPTH)) begin
                        out_wr_d = new_ptr;
                    end else begin
                        ptr_err_d = 1'b1;
                    end
                end
                REG_CTRL: begin
                    ctrl_d = wdata[1:0];
                end
                REG_STATUS: begin
                    if (wdata[STAT_PTR_ERR]) begin
                        ptr_err_d = 1'b0;
                    end
                end
`ifdef MSG_QUEUE_WATERMARK_EN
                REG_WATERMARK: begin
                    wmark_d = new_ptr;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Register state with synchronous reset; rings are intentionally not reset
    always_ff @(posedge clk) begin
        if (rst) begin
            in_rd_q   <= '0;
            in_wr_q   <= '0;
            out_rd_q  <= '0;
            out_wr_q  <= '0;
            ctrl_q    <= '0;
            ptr_err_q <= 1'b0;
`ifdef MSG_QUEUE_WATERMARK_EN
            wmark_q   <= PTR_W'(1);
`endif
        end else begin
            in_rd_q   <= in_rd_d;
            in_wr_q   <= in_wr_d;
            out_rd_q  <= out_rd_d;
            out_wr_q  <= out_wr_d;
            ctrl_q    <= ctrl_d;
            ptr_err_q <= ptr_err_d;
`ifdef MSG_QUEUE_WATERMARK_EN
            wmark_q   <= wmark_d;
`endif
        end
    end

    // Ring storage: stream fills the inbound ring, CPU fills the outbound ring
    always_ff @(posedge clk) begin
        if (push) begin
            in_ring_q[in_wr_q[LOG_D-1:0]] <= in_data;
        end
        if (mem_we) begin
            out_ring_q[mem_idx] <= wdata[DATA_W-1:0];
        end
    end

    // CPU view of the selected register and ring slot
    always_comb begin
        reg_rdata = '0;
        case (reg_off_e'(reg_sel))
            REG_IN_RD_PTR:  reg_rdata = 32'(in_rd_q);
            REG_IN_WR_PTR:  reg_rdata = 32'(in_wr_q);
            REG_OUT_RD_PTR: reg_rdata = 32'(out_rd_q);
            REG_OUT_WR_PTR: reg_rdata = 32'(out_wr_q);
            REG_CTRL:       reg_rdata = 32'(ctrl_q);
            REG_STATUS:     reg_rdata = 32'(status);
`ifdef MSG_QUEUE_WATERMARK_EN
            REG_WATERMARK:  reg_rdata = 32'(wmark_q);
`endif
            default:        reg_rdata = '0;
        endcase
        mem_rdata = mem_dir ? 32'(out_ring_q[mem_idx]) : 32'(in_ring_q[mem_idx]);
    end

endmodule

// File: rtl/multi_chan_message_queue.sv
// N-channel bidirectional message queue. Decodes the CPU word address into
// per-channel register and ring accesses, muxes and registers read data, and
// ORs the channel interrupt conditions into a registered level IRQ.
// Optional feature macro: MSG_QUEUE_WATERMARK_EN (handled in msg_queue_chan).
module multi_chan_message_queue
    import msg_queue_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       read_en,
    input  logic                       write_en,
    input  logic [31:0]                write_data,
    output logic [31:0]                read_data,
    input  logic [NUM_CHAN-1:0]        in_valid,
    input  logic [NUM_CHAN*DATA_W-1:0] in_data,
    output logic [NUM_CHAN-1:0]        in_ready,
    output logic [NUM_CHAN-1:0]        out_valid,
    output logic [NUM_CHAN*DATA_W-1:0] out_data,
    input  logic [NUM_CHAN-1:0]        out_ready,
    output logic                       irq
);

    localparam int LOG_D = $clog2(DEPTH);

    logic              is_reg;
    logic [6:0]        reg_chan;
    logic [2:0]        reg_sel;
    logic [ADDR_W-1:0] mem_off;
    logic [ADDR_W-1:0] mem_chan;
    logic              mem_dir;
    logic [LOG_D-1:0]  mem_idx;

    logic [NUM_CHAN-1:0] reg_hit, mem_hit, irq_cond;
    logic [31:0]         ch_reg_rdata [NUM_CHAN];
    logic [31:0]         ch_mem_rdata [NUM_CHAN];
    logic [31:0]         rd_mux;

    logic [31:0] read_data_q, read_data_d;
    logic        irq_q, irq_d;

    // Split the word address into register-window and ring-window fields
    always_comb begin
        is_reg   = (addr < ADDR_W'(MEM_BASE));
        reg_chan = addr[9:3];
        reg_sel  = addr[2:0];
        mem_off  = addr - ADDR_W'(MEM_BASE);
        mem_chan = mem_off >> (LOG_D + 1);
        mem_dir  = mem_off[LOG_D];
        mem_idx  = mem_off[LOG_D-1:0];
    end

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        assign reg_hit[c] = is_reg && (reg_chan == 7'(c));
        assign mem_hit[c] = !is_reg && (mem_chan == ADDR_W'(c));

        msg_queue_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .reg_sel   (reg_sel),
            .reg_we    (write_en && reg_hit[c]),
            .wdata     (write_data),
            .mem_dir   (mem_dir),
            .mem_idx   (mem_idx),
            .mem_we    (write_en && mem_hit[c] && mem_dir),
            .reg_rdata (ch_reg_rdata[c]),
            .mem_rdata (ch_mem_rdata[c]),
            .in_valid  (in_valid[c]),
            .in_data   (in_data[c*DATA_W +: DATA_W]),
            .in_ready  (in_ready[c]),
            .out_valid (out_valid[c]),
            .out_data  (out_data[c*DATA_W +: DATA_W]),
            .out_ready (out_ready[c]),
            .irq_cond  (irq_cond[c])
        );
    end

    // Select the addressed channel's data; anything unmapped reads as zero
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (reg_hit[c]) begin
                rd_mux = ch_reg_rdata[c];
            end
            if (mem_hit[c]) begin
                rd_mux = ch_mem_rdata[c];
            end
        end
    end

    // Read data is zero on write cycles and holds its value when idle
    always_comb begin
        read_data_d = read_data_q;
        if (write_en) begin
            read_data_d = '0;
        end else if (read_en) begin
            read_data_d = rd_mux;
        end
        irq_d = |irq_cond;
    end

    // Output registers for read data and the interrupt level
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            irq_q       <= irq_d;
        end
    end

    assign read_data = read_data_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_multi_chan_message_queue.sv
// Self-checking bench for multi_chan_message_queue: a table of CPU register
// accesses followed by hand-written stream/pointer sequences. Honors the
// MSG_QUEUE_WATERMARK_EN macro for the watermark sequence.
module tb_multi_chan_message_queue;

    localparam int NUM_CHAN = 4;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 256;
    localparam int ADDR_W   = 16;

    logic                       clk;
    logic                       rst;
    logic [ADDR_W-1:0]          addr;
    logic                       read_en;
    logic                       write_en;
    logic [31:0]                write_data;
    logic [31:0]                read_data;
    logic [NUM_CHAN-1:0]        in_valid;
    logic [NUM_CHAN*DATA_W-1:0] in_data;
    logic [NUM_CHAN-1:0]        in_ready;
    logic [NUM_CHAN-1:0]        out_valid;
    logic [NUM_CHAN*DATA_W-1:0] out_data;
    logic [NUM_CHAN-1:0]        out_ready;
    logic                       irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } cpu_vec_t;

    cpu_vec_t vecs [16];

    multi_chan_message_queue #(
        .NUM_CHAN (NUM_CHAN),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .read_en    (read_en),
        .write_en   (write_en),
        .write_data (write_data),
        .read_data  (read_data),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] regAddr(input int ch, input int r);
        return 16'(ch * 8 + r);
    endfunction

    function automatic logic [15:0] memAddr(input int ch, input int dir, input int idx);
        return 16'('h400 + ch * 2 * DEPTH + dir * DEPTH + idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuRead(input logic [15:0] a, output logic [31:0] d);
        addr = a; read_en = 1'b1; write_en = 1'b0;
        tick();
        read_en = 1'b0;
        d = read_data;
    endtask

    task automatic cpuWrite(input logic [15:0] a, input logic [31:0] d);
        addr = a; write_data = d; write_en = 1'b1; read_en = 1'b0;
        tick();
        write_en = 1'b0;
    endtask

    task automatic applyStimulus(input cpu_vec_t v);
        logic [31:0] d;
        if (v.wr) begin
            cpuWrite(v.addr, v.wdata);
            d = read_data;
        end else begin
            cpuRead(v.addr, d);
        end
        checkOutput(v.name, d, v.exp);
    endtask

    task automatic readCheck(input logic [15:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        cpuRead(a, d);
        checkOutput(name, d, exp);
    endtask

    task automatic pushWord(input int ch, input logic [31:0] d);
        in_valid[ch] = 1'b1;
        in_data[ch*DATA_W +: DATA_W] = d;
        tick();
        in_valid[ch] = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int n;

        vecs[0]  = '{1'b0, regAddr(0, 0), 32'h0, 32'h0, "rst_c0_in_rd"};
        vecs[1]  = '{1'b0, regAddr(1, 1), 32'h0, 32'h0, "rst_c1_in_wr"};
        vecs[2]  = '{1'b0, regAddr(2, 2), 32'h0, 32'h0, "rst_c2_out_rd"};
        vecs[3]  = '{1'b0, regAddr(3, 3), 32'h0, 32'h0, "rst_c3_out_wr"};
        vecs[4]  = '{1'b0, regAddr(0, 5), 32'h0, 32'h2, "rst_c0_status"};
        vecs[5]  = '{1'b1, regAddr(0, 4), 32'hFFFF_FFF1, 32'h0, "ctrl_wr_rdzero"};
        vecs[6]  = '{1'b0, regAddr(0, 4), 32'h0, 32'h1, "c0_ctrl_masked"};
        vecs[7]  = '{1'b0, regAddr(0, 7), 32'h0, 32'h0, "c0_reserved"};
        vecs[8]  = '{1'b1, regAddr(0, 4), 32'h0, 32'h0, "ctrl_clear"};
        vecs[9]  = '{1'b0, regAddr(0, 5), 32'h0, 32'h2, "c0_status_again"};
        vecs[10] = '{1'b0, regAddr(4, 5), 32'h0, 32'h0, "unmapped_chan"};
        vecs[11] = '{1'b1, regAddr(0, 3), 32'h0000_0603, 32'h0, "out_wr_masked_wr"};
        vecs[12] = '{1'b0, regAddr(0, 3), 32'h0, 32'h3, "out_wr_masked_rd"};
        vecs[13] = '{1'b0, 16'hC00, 32'h0, 32'h0, "mem_out_of_range"};
        vecs[14] = '{1'b1, regAddr(0, 3), 32'h0, 32'h0, "out_wr_zero_wr"};
        vecs[15] = '{1'b0, regAddr(0, 3), 32'h0, 32'h0, "out_wr_zero_rd"};

        rst = 1'b1; addr = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
        in_valid = '0; in_data = '0; out_ready = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state of the stream side and outputs
        checkOutput("rst_in_ready", 32'(in_ready), 32'hF);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_read_data", read_data, 32'h0);

        foreach (vecs[i]) applyStimulus(vecs[i]);
        checkOutput("table_irq", 32'(irq), 32'h0);

        // Channel 1 inbound push and CPU drain
        $display("[TB] inbound push on channel 1");
        for (int i = 0; i < 4; i++) begin
            checkOutput("c1_ready_push", 32'(in_ready[1]), 32'h1);
            pushWord(1, 32'hA0 + 32'(i));
        end
        readCheck(regAddr(1, 1), 32'h4, "c1_in_wr_after_push");
        for (int i = 0; i < 4; i++) begin
            readCheck(memAddr(1, 0, i), 32'hA0 + 32'(i), "c1_in_ring_rd");
        end
        tick();
        checkOutput("read_data_hold", read_data, 32'hA3);
        readCheck(regAddr(1, 5), 32'h3, "c1_status_avail");
        cpuWrite(memAddr(1, 0, 0), 32'hDEAD);
        readCheck(memAddr(1, 0, 0), 32'hA0, "c1_in_ring_ro");
        cpuWrite(regAddr(1, 0), 32'h4);
        readCheck(regAddr(1, 5), 32'h2, "c1_status_drained");
        cpuWrite(regAddr(1, 0), 32'h5);
        readCheck(regAddr(1, 0), 32'h4, "c1_in_rd_rejected");
        readCheck(regAddr(1, 5), 32'h6, "c1_ptr_err_set");
        cpuWrite(regAddr(1, 5), 32'h4);
        readCheck(regAddr(1, 5), 32'h2, "c1_ptr_err_w1c");

        // Channel 0 fill to DEPTH
        $display("[TB] fill channel 0");
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) checkOutput("c0_ready_at_255", 32'(in_ready[0]), 32'h1);
            in_valid[0] = 1'b1;
            in_data[31:0] = 32'(i);
            tick();
        end
        checkOutput("c0_full_not_ready", 32'(in_ready[0]), 32'h0);
        in_data[31:0] = 32'hBAD;
        tick(); tick();
        in_valid[0] = 1'b0;
        readCheck(regAddr(0, 1), 32'h100, "c0_in_wr_full");
        readCheck(memAddr(0, 0, DEPTH - 1), 32'hFF, "c0_last_slot");
        readCheck(memAddr(0, 0, 0), 32'h0, "c0_first_slot_kept");
        cpuWrite(regAddr(0, 0), 32'h1);
        checkOutput("c0_ready_after_free", 32'(in_ready[0]), 32'h1);

        // Channel 2 outbound wrap across the ring end
        $display("[TB] outbound wrap on channel 2");
        cpuWrite(regAddr(2, 3), 32'd255);
        out_ready[2] = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        out_ready[2] = 1'b0;
        checkOutput("c2_drained_valid", 32'(out_valid[2]), 32'h0);
        readCheck(regAddr(2, 2), 32'd255, "c2_out_rd_255");
        cpuWrite(memAddr(2, 1, 255), 32'h11);
        cpuWrite(memAddr(2, 1, 0), 32'h22);
        readCheck(memAddr(2, 1, 255), 32'h11, "c2_out_ring_rw");
        cpuWrite(regAddr(2, 3), 32'd257);
        checkOutput("c2_valid_pending", 32'(out_valid[2]), 32'h1);
        checkOutput("c2_head_0x11", out_data[2*DATA_W +: DATA_W], 32'h11);
        out_ready[2] = 1'b1;
        tick();
        checkOutput("c2_head_0x22", out_data[2*DATA_W +: DATA_W], 32'h22);
        checkOutput("c2_valid_second", 32'(out_valid[2]), 32'h1);
        tick();
        out_ready[2] = 1'b0;
        checkOutput("c2_empty_after_wrap", 32'(out_valid[2]), 32'h0);

        // Overlong outbound pointer write is rejected
        cpuWrite(regAddr(2, 3), 32'd257 + 32'(DEPTH) + 32'd1);
        readCheck(regAddr(2, 3), 32'd257, "c2_out_wr_rejected");
        readCheck(regAddr(2, 5), 32'h6, "c2_ptr_err_set");
        cpuWrite(regAddr(2, 5), 32'h4);
        readCheck(regAddr(2, 5), 32'h2, "c2_ptr_err_w1c");
        checkOutput("pre_irq_idle", 32'(irq), 32'h0);

        // Channel 3 interrupt behaviour
        $display("[TB] interrupt on channel 3");
        cpuWrite(regAddr(3, 4), 32'h1);
        tick();
        checkOutput("c3_irq_empty", 32'(irq), 32'h0);
        pushWord(3, 32'h55);
        checkOutput("c3_irq_not_yet", 32'(irq), 32'h0);
        tick();
        checkOutput("c3_irq_after_push", 32'(irq), 32'h1);
        n = 1;
`ifdef MSG_QUEUE_WATERMARK_EN
        cpuWrite(regAddr(3, 6), 32'h3);
        tick();
        checkOutput("wm_irq_below", 32'(irq), 32'h0);
        readCheck(regAddr(3, 6), 32'h3, "wm_readback");
        pushWord(3, 32'h56);
        tick();
        checkOutput("wm_irq_count2", 32'(irq), 32'h0);
        pushWord(3, 32'h57);
        tick();
        checkOutput("wm_irq_count3", 32'(irq), 32'h1);
        cpuWrite(regAddr(3, 6), 32'h0);
        readCheck(regAddr(3, 6), 32'h0, "wm_zero_readback");
        checkOutput("wm_zero_as_one", 32'(irq), 32'h1);
        n = 3;
`else
        cpuWrite(regAddr(3, 6), 32'h3);
        readCheck(regAddr(3, 6), 32'h0, "wm_absent_reads0");
        tick();
        checkOutput("wm_absent_irq", 32'(irq), 32'h1);
`endif
        cpuWrite(regAddr(3, 0), 32'(n));
        tick();
        checkOutput("c3_irq_cleared", 32'(irq), 32'h0);
        cpuWrite(regAddr(3, 4), 32'h2);
        tick();
        checkOutput("c3_out_ie_irq", 32'(irq), 32'h1);
        cpuWrite(regAddr(3, 4), 32'h0);
        tick();
        checkOutput("c3_irq_off", 32'(irq), 32'h0);

        // Reset while channel 0 holds messages and channel 2 has a pending write
        cpuWrite(regAddr(2, 3), 32'd258);
        cpuWrite(regAddr(3, 4), 32'h1);
        pushWord(3, 32'h99);
        in_valid[0] = 1'b1;
        rst = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        rst = 1'b0;
        tick();
        checkOutput("midrst_in_ready", 32'(in_ready), 32'hF);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_irq", 32'(irq), 32'h0);
        checkOutput("midrst_read_data", read_data, 32'h0);
        readCheck(regAddr(0, 1), 32'h0, "midrst_c0_in_wr");
        readCheck(regAddr(3, 4), 32'h0, "midrst_c3_ctrl");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
